// File: rtl/sindrv_mc.sv
// Multi-channel sample-buffer burst driver. It replays one shared sample table to a
// memory-mapped sink, serving the channels round-robin, each with its own phase-offset read index.
module sindrv_mc #(
   parameter int          DW         = 32,
   parameter int          AW         = 32,
   parameter int          NCH        = 4,
   parameter int          DEPTH      = 256,
   parameter logic [31:0] BASE_ADDR  = 32'hA000_0000,
   parameter logic [31:0] CH_STRIDE  = 32'h0000_1000,
   parameter int          PHASE_STEP = 64,
   parameter int          FIXED_LEN  = 4,
   parameter int          GAP_CYC    = 2,
   parameter logic [7:0]  SEED       = 8'hA5
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     enable,
   input  logic                     mode,
   input  logic                     si_ready,
   input  logic                     ld_we,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [DW-1:0]            ld_data,
   output logic                     exec,
   output logic                     we,
   output logic [AW-1:0]            si_address,
   output logic [DW-1:0]            si_data,
   output logic                     busy,
   output logic                     burst_done,
   output logic [15:0]              beat_cnt
);

   // state | meaning
   // IDLE  | waiting for enable
   // SETUP | latch length, step LFSR, register first beat
   // XFER  | presenting beats until the last one is accepted
   // GAP   | idle spacing between bursts, GAP_CYC cycles

   localparam int IW = $clog2(DEPTH);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [IW-1:0] idx [NCH];
   logic [CW-1:0] ch;
   logic [7:0]    lfsr;
   logic          lfsr_fb;
   logic [4:0]    rem;
   logic [3:0]    gap_cnt;
   logic          accept, last;
   logic [IW-1:0] cur_idx, beat_idx;
   logic [AW-1:0] beat_addr;
   logic [4:0]    len_sel;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      exec       = 1'b0;
      we         = 1'b0;
      busy       = (state != IDLE);
      burst_done = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE:  if (enable) state_nxt = SETUP;
         SETUP: state_nxt = XFER;
         XFER: begin
            exec       = 1'b1;
            we         = 1'b1;
            accept     = si_ready;
            last       = si_ready && (rem == 5'd1);
            burst_done = last;
            if (last) state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
         end
         GAP:   if (gap_cnt == 4'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // SETUP registers the beat at the current index; an accept registers the following one
   always_comb begin
      cur_idx   = idx[ch];
      beat_idx  = (state == SETUP) ? cur_idx : cur_idx + IW'(1);
      beat_addr = AW'(BASE_ADDR) + AW'(ch) * AW'(CH_STRIDE) + AW'(beat_idx) * AW'(DW / 8);
      len_sel   = mode ? ({1'b0, lfsr[3:0]} + 5'd1) : 5'(FIXED_LEN);
      lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   end

   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ch         <= '0;
         lfsr       <= SEED;
         rem        <= '0;
         gap_cnt    <= '0;
         si_address <= '0;
         si_data    <= '0;
         beat_cnt   <= '0;
         for (int c = 0; c < NCH; c++) idx[c] <= IW'((c * PHASE_STEP) % DEPTH);
      end else begin
         if (state == SETUP) begin
            rem        <= len_sel;
            lfsr       <= {lfsr[6:0], lfsr_fb};
            si_address <= beat_addr;
            si_data    <= mem[beat_idx];
         end
         if (accept) begin
            idx[ch]  <= cur_idx + IW'(1);
            beat_cnt <= beat_cnt + 16'd1;
            rem      <= rem - 5'd1;
            if (last) begin
               ch      <= (ch == CW'(NCH - 1)) ? '0 : ch + CW'(1);
               gap_cnt <= 4'(GAP_CYC - 1);
            end else begin
               si_address <= beat_addr;
               si_data    <= mem[beat_idx];
            end
         end else if (state == GAP && gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sindrv_mc.sv
// Scoreboard bench for sindrv_mc: a behavioural model queues expected beats at burst setup,
// and a negedge monitor compares every presented and accepted beat against the queue.
module tb_sindrv_mc;

   localparam int DEPTH = 256;
   localparam int NCH   = 4;
   localparam int GAPC  = 2;
   localparam int FLEN  = 4;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        enable = 1'b0, mode = 1'b0, si_ready = 1'b1, ld_we = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        exec, we, busy, burst_done;
   logic [31:0] si_address, si_data;
   logic [15:0] beat_cnt;

   sindrv_mc dut (
      .clk(clk), .nreset(nreset), .enable(enable), .mode(mode), .si_ready(si_ready),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .exec(exec), .we(we),
      .si_address(si_address), .si_data(si_data), .busy(busy), .burst_done(burst_done),
      .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {8'hC5, b, ~b, 8'(i * 3)};
   endfunction

   // reference model
   typedef enum {M_IDLE, M_SETUP, M_XFER, M_GAP} mstate_t;
   typedef struct packed { logic [31:0] a; logic [31:0] d; } beat_t;

   beat_t       q[$];
   mstate_t     m_state;
   logic [31:0] m_mem [DEPTH];
   int          m_idx [NCH];
   int          m_ch, m_rem, m_gap, m_len;
   logic [7:0]  m_lfsr;
   logic [15:0] m_cnt;
   int          n_done = 0, obs_len, last_len = 0;
   logic [31:0] first_addr = '0, first_data = '0;
   logic        seen_wrap = 1'b0;

   always @(negedge clk) begin
      if (!nreset) begin
         q.delete();
         m_state = M_IDLE;
         for (int c = 0; c < NCH; c++) m_idx[c] = (c * 64) % DEPTH;
         m_ch = 0; m_rem = 0; m_gap = 0; m_lfsr = 8'hA5; m_cnt = '0; obs_len = 0;
      end else begin
         chk("busy", busy, m_state != M_IDLE);
         chk("exec", exec, m_state == M_XFER);
         chk("we", we, m_state == M_XFER);
         chk("burst_done", burst_done, m_state == M_XFER && si_ready && m_rem == 1);
         chk("beat_cnt", beat_cnt, m_cnt);
         case (m_state)
            M_IDLE: if (enable) m_state = M_SETUP;
            M_SETUP: begin
               m_len  = mode ? int'(m_lfsr[3:0]) + 1 : FLEN;
               m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
               for (int k = 0; k < m_len; k++) begin
                  q.push_back({32'hA000_0000 + 32'(m_ch) * 32'h1000 + 32'(m_idx[m_ch]) * 32'd4,
                               m_mem[m_idx[m_ch]]});
                  m_idx[m_ch] = (m_idx[m_ch] + 1) % DEPTH;
               end
               m_ch    = (m_ch + 1) % NCH;
               m_rem   = m_len;
               m_state = M_XFER;
            end
            M_XFER: begin
               if (q.size() == 0) chk("queue_empty", 64'd1, 64'd0);
               else begin
                  chk("si_address", si_address, q[0].a);
                  chk("si_data", si_data, q[0].d);
                  if (si_ready) begin
                     if (obs_len == 0) begin first_addr = si_address; first_data = si_data; end
                     if (si_address == 32'hA000_3000) seen_wrap = 1'b1;
                     void'(q.pop_front());
                     obs_len++;
                     m_cnt++;
                     m_rem--;
                     if (m_rem == 0) begin
                        n_done++;
                        last_len = obs_len;
                        obs_len  = 0;
                        m_gap    = GAPC;
                        m_state  = (GAPC == 0) ? M_IDLE : M_GAP;
                     end
                  end
               end
            end
            M_GAP: begin
               m_gap--;
               if (m_gap == 0) m_state = M_IDLE;
            end
            default: m_state = M_IDLE;
         endcase
         if (ld_we) m_mem[ld_addr] = ld_data;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_exec"}, exec, 0);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, burst_done, 0);
      chk({tag, "_addr"}, si_address, 0);
      chk({tag, "_data"}, si_data, 0);
      chk({tag, "_cnt"}, beat_cnt, 0);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #2 nreset = 1'b0;
      #1 chk_reset_outputs(tag);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 nreset = 1'b1;
   endtask

   task automatic wait_done(input int target, input int max_cyc);
      int c = 0;
      while (n_done < target && c < max_cyc) begin @(negedge clk); c++; end
      if (n_done < target) chk("wait_done_timeout", 64'(n_done), 64'(target));
   endtask

   task automatic wait_exec(input int max_cyc);
      int c = 0;
      while (exec !== 1'b1 && c < max_cyc) begin @(negedge clk); c++; end
      if (exec !== 1'b1) chk("wait_exec_timeout", exec, 1);
   endtask

   task automatic wait_idle(input int max_cyc);
      int c = 0;
      @(posedge clk); #1 enable = 1'b0;
      while (busy !== 1'b0 && c < max_cyc) begin @(negedge clk); c++; end
      if (busy !== 1'b0) chk("wait_idle_timeout", busy, 0);
   endtask

   initial begin
      int base;
      logic [3:0] stall_pat;
      repeat (2) @(negedge clk);
      chk_reset_outputs("por");
      @(posedge clk); #1 nreset = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #1 ld_we = 1'b1; ld_addr = 8'(i); ld_data = pat(i);
      end
      @(posedge clk); #1 ld_we = 1'b0;

      // fixed-length bursts, sink always ready
      enable = 1'b1; mode = 1'b0; si_ready = 1'b1;
      wait_done(1, 40);
      chk("burst1_addr", first_addr, 32'hA000_0000);
      chk("burst1_len", 64'(last_len), 4);
      wait_done(2, 40);
      chk("burst2_addr", first_addr, 32'hA000_1100);
      chk("burst2_data", first_data, pat(64));

      // 1-0-0-1 stall mid-burst, then random backpressure
      wait_exec(40);
      stall_pat = 4'b1001;
      for (int i = 3; i >= 0; i--) begin
         @(posedge clk); #1 si_ready = stall_pat[i];
      end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1 si_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1 si_ready = 1'b1;

      // channel 3 index runs 192..255 and wraps back to 0
      wait_done(68, 1500);
      chk("ch3_wrap_seen", seen_wrap, 1);
      wait_idle(40);

      // write to the stalled beat's index; stalled beat keeps old data
      do_reset("rst_a");
      si_ready = 1'b0; enable = 1'b1;
      wait_exec(20);
      @(posedge clk); #1 ld_we = 1'b1; ld_addr = 8'd0; ld_data = 32'h1234_5678;
      @(posedge clk); #1 ld_we = 1'b0;
      @(negedge clk);
      chk("stale_data", si_data, pat(0));
      @(posedge clk); #1 si_ready = 1'b1;
      @(posedge clk); #1 si_ready = 1'b0;
      @(negedge clk);
      chk("stall_beat1_data", si_data, pat(1));

      // reset in mid-XFER: no pulse, phase offsets restored, new buffer data visible
      base = n_done;
      do_reset("rst_xfer");
      chk("no_done_after_rst", 64'(n_done), 64'(base));
      si_ready = 1'b1;
      wait_done(base + 1, 40);
      chk("post_rst_addr", first_addr, 32'hA000_0000);
      chk("post_rst_new_data", first_data, 32'h1234_5678);
      wait_idle(40);

      // random length: 6 from seed A5, then 11 from the next LFSR state 4A
      do_reset("rst_b");
      mode = 1'b1; enable = 1'b1;
      base = n_done;
      wait_done(base + 1, 60);
      chk("m1_len1", 64'(last_len), 6);
      wait_done(base + 2, 60);
      chk("m1_len2", 64'(last_len), 11);
      wait_idle(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
